gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a computation on x_i/y_i.
REQ-005 The block SHALL have port x_i, input, WIDTH bits: first unsigned operand, sampled only on an accepted start.
REQ-006 The block SHALL have port y_i, input, WIDTH bits: second unsigned operand, sampled only on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: high while d_o holds a valid result.
REQ-009 The block SHALL have port d_o, output, WIDTH bits: GCD result.
REQ-010 The block SHALL have port iter_o, output, WIDTH bits: number of subtraction steps taken for the result on d_o.

Function
REQ-011 The controller SHALL implement three states: IDLE, RUN, DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; on the accepting edge x_i/y_i load internal X/Y, the iteration counter clears, done drops, state goes to RUN.
REQ-013 start asserted in RUN SHALL be ignored, with no effect on X, Y, counter or outputs.
REQ-014 In RUN, if X==0 or Y==0, then on the next edge d_o SHALL load X|Y and state SHALL go to DONE (gcd(0,0)=0).
REQ-015 Otherwise in RUN, if X==Y, then on the next edge d_o SHALL load X and state SHALL go to DONE.
REQ-016 Otherwise in RUN, if X<Y (unsigned), then Y<=Y-X; else X<=X-Y; in both cases the counter SHALL increment by 1.
REQ-017 Subtraction SHALL always be larger minus smaller, so no wrap-around occurs and X/Y never become 0 during RUN.
REQ-018 The counter SHALL be WIDTH bits; its maximum reachable value is 2^WIDTH-2, so it SHALL never wrap and needs no saturation.
REQ-019 Latency SHALL be: with start accepted at edge 0 and N subtractions, done rises after edge N+1.
REQ-020 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE; busy and done SHALL never be high together.
REQ-021 On the edge entering DONE, iter_o SHALL load the counter value.
REQ-022 d_o and iter_o SHALL hold their last values through DONE and IDLE until the next DONE entry, and SHALL not change during RUN.
REQ-023 A start accepted in DONE (back-to-back) SHALL behave identically to a start accepted in IDLE.
REQ-024 DONE SHALL persist until the next accepted start; there SHALL be no other exit from DONE except reset.

Reset
REQ-025 reset low SHALL immediately, without waiting for clk, force state to IDLE, busy=0, done=0, d_o=0, iter_o=0, X=Y=0, counter=0.
REQ-026 reset asserted mid-RUN SHALL abort the computation, with no result published.
REQ-027 After reset deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-028 The bench SHALL check: WIDTH=8, x=12, y=8, start at edge 0 -> busy after edge 0, done after edge 3, d_o=4, iter_o=2.
REQ-029 The bench SHALL check: x=0, y=7 -> done after edge 1, d_o=7, iter_o=0; then x=0, y=0 -> d_o=0, iter_o=0.
REQ-030 The bench SHALL check: x=255, y=1 -> d_o=1, iter_o=254, done after edge 255; and x=9, y=9 -> d_o=9, iter_o=0.
REQ-031 The bench SHALL check: start with x=21, y=6 pulsed again at edge 2 with x=5, y=5 -> second start ignored, d_o=3, iter_o=4.
REQ-032 The bench SHALL check: reset pulsed low asynchronously mid-RUN -> outputs zero immediately; next start with x=18, y=12 -> d_o=6, iter_o=2.
REQ-033 The bench SHALL check: back-to-back start in the DONE cycle -> done drops after that edge, and the new result is correct with previous outputs held until the new DONE.

Source files
------------

// File: rtl/gcd_engine.sv
// Subtractive GCD engine: loads two unsigned operands on start, repeatedly
// subtracts the smaller from the larger, and publishes the GCD plus step count.
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_o,
  output logic [WIDTH-1:0] iter_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_iter;
  logic             r_busy;
  logic             r_done;

  // Result registers only move on DONE entry, so they hold through RUN and IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_x     <= x_i;
            r_y     <= y_i;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_x == '0 || r_y == '0) begin
            r_d     <= r_x | r_y;
            r_iter  <= r_cnt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_x == r_y) begin
            r_d     <= r_x;
            r_iter  <= r_cnt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_x < r_y) begin
            r_y   <= r_y - r_x;
            r_cnt <= r_cnt + ONE;
          end else begin
            r_x   <= r_x - r_y;
            r_cnt <= r_cnt + ONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign d_o    = r_d;
  assign iter_o = r_iter;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: a reference subtraction model pushes expected
// results at issue time; each scenario pops and compares when done rises.
module tb_gcd_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] xIn = '0;
  logic [W-1:0] yIn = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] dOut;
  logic [W-1:0] iterOut;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] iter;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  gcd_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_i   (xIn),
    .y_i   (yIn),
    .busy  (busy),
    .done  (done),
    .d_o   (dOut),
    .iter_o(iterOut)
  );

  always #5 clk = ~clk;

  // Reference Euclid-by-subtraction; latency is one edge per step plus the finish edge.
  function automatic exp_t gcdModel(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W-1:0] a = x;
    logic [W-1:0] b = y;
    int n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a < b) b = b - a;
      else       a = a - b;
      n++;
    end
    e.d    = (a == 0 || b == 0) ? (a | b) : a;
    e.iter = W'(n);
    e.lat  = n + 1;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    xIn   = x;
    yIn   = y;
    sb.push_back(gcdModel(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done, noting whether outputs moved during RUN or busy/done overlapped.
  task automatic waitDone(input int firstCycle, output int cycles, output bit timedOut,
                          output bit heldOk, output bit exclOk);
    logic [W-1:0] heldD = dOut;
    logic [W-1:0] heldI = iterOut;
    cycles   = firstCycle;
    timedOut = 1'b1;
    heldOk   = 1'b1;
    exclOk   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy && done) exclOk = 1'b0;
      if (done) begin
        timedOut = 1'b0;
        break;
      end
      if (dOut !== heldD || iterOut !== heldI) heldOk = 1'b0;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({busy, done, dOut, iterOut} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state got busy=%b done=%b d=%0d iter=%0d want all 0",
               busy, done, dOut, iterOut);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_cases(input string name, input logic [W-1:0] xs[], input logic [W-1:0] ys[]);
    exp_t e;
    int cyc;
    bit to, held, excl;
    for (int k = 0; k < xs.size(); k++) begin
      issue(xs[k], ys[k]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_busy_after_start[%0d] got busy=%b done=%b want 1/0", name, k, busy, done);
      end
      waitDone(0, cyc, to, held, excl);
      e = sb.pop_front();
      checks++;
      if (to || cyc !== e.lat) begin
        failures++;
        $display("[TB] FAIL %s_latency[%0d] got %0d (timeout=%b) want %0d", name, k, cyc, to, e.lat);
      end
      checks++;
      if (dOut !== e.d || iterOut !== e.iter) begin
        failures++;
        $display("[TB] FAIL %s_result[%0d] got d=%0d iter=%0d want d=%0d iter=%0d",
                 name, k, dOut, iterOut, e.d, e.iter);
      end
      checks++;
      if (!held || !excl) begin
        failures++;
        $display("[TB] FAIL %s_run_outputs[%0d] got held=%b excl=%b want 1/1", name, k, held, excl);
      end
    end
  endtask

  task automatic test_basic;
    int cyc;
    bit to, held, excl;
    issue(8'd12, 8'd8);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy got %b want 1", busy);
    end
    waitDone(0, cyc, to, held, excl);
    void'(sb.pop_front());
    checks++;
    if (to || cyc !== 3 || dOut !== 8'd4 || iterOut !== 8'd2) begin
      failures++;
      $display("[TB] FAIL basic_12_8 got edge=%0d d=%0d iter=%0d want edge=3 d=4 iter=2",
               cyc, dOut, iterOut);
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int cyc;
    bit to, held, excl;
    issue(8'd21, 8'd6);
    @(posedge clk);
    #1;
    start = 1'b1;
    xIn   = 8'd5;
    yIn   = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(2, cyc, to, held, excl);
    e = sb.pop_front();
    checks++;
    if (to || dOut !== 8'd3 || iterOut !== 8'd4 || cyc !== e.lat) begin
      failures++;
      $display("[TB] FAIL ignore_start got edge=%0d d=%0d iter=%0d want edge=%0d d=3 iter=4",
               cyc, dOut, iterOut, e.lat);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    bit to, held, excl;
    issue(8'd255, 8'd1);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, dOut, iterOut} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got busy=%b done=%b d=%0d iter=%0d want all 0",
               busy, done, dOut, iterOut);
    end
    sb.delete();
    #3;
    reset = 1'b1;
    issue(8'd18, 8'd12);
    waitDone(0, cyc, to, held, excl);
    void'(sb.pop_front());
    checks++;
    if (to || dOut !== 8'd6 || iterOut !== 8'd2 || cyc !== 3) begin
      failures++;
      $display("[TB] FAIL after_reset got edge=%0d d=%0d iter=%0d want edge=3 d=6 iter=2",
               cyc, dOut, iterOut);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int cyc;
    bit to, held, excl;
    issue(8'd12, 8'd8);
    waitDone(0, cyc, to, held, excl);
    void'(sb.pop_front());
    issue(8'd21, 8'd6);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || dOut !== 8'd4 || iterOut !== 8'd2) begin
      failures++;
      $display("[TB] FAIL b2b_restart got done=%b busy=%b d=%0d iter=%0d want 0/1 d=4 iter=2",
               done, busy, dOut, iterOut);
    end
    waitDone(0, cyc, to, held, excl);
    e = sb.pop_front();
    checks++;
    if (to || !held || cyc !== e.lat || dOut !== e.d || iterOut !== e.iter) begin
      failures++;
      $display("[TB] FAIL b2b_result got edge=%0d held=%b d=%0d iter=%0d want edge=%0d held=1 d=%0d iter=%0d",
               cyc, held, dOut, iterOut, e.lat, e.d, e.iter);
    end
  endtask

  initial begin
    logic [W-1:0] zx[] = '{8'd0, 8'd0};
    logic [W-1:0] zy[] = '{8'd7, 8'd0};
    logic [W-1:0] bx[] = '{8'd255, 8'd9, 8'd100};
    logic [W-1:0] by[] = '{8'd1, 8'd9, 8'd35};
    test_reset();
    test_basic();
    test_cases("zero", zx, zy);
    test_cases("boundary", bx, by);
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
